// File: rtl/reg_file_sb.sv
`default_nettype none
// reg_file_sb: parametrised register file with two registered read ports, optional
// write-to-read bypass, zero register, and an issue/write-back busy scoreboard.
// Revision: 1.0
module reg_file_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Write,
  input  logic [ADDR_W-1:0] WR,
  input  logic [DATA_W-1:0] WD,
  input  logic              RE,
  input  logic [ADDR_W-1:0] PR1,
  input  logic [ADDR_W-1:0] PR2,
  output logic [DATA_W-1:0] RD1,
  output logic [DATA_W-1:0] RD2,
  input  logic              Issue,
  input  logic [ADDR_W-1:0] IssueRd,
  output logic              Hazard1,
  output logic              Hazard2,
  output logic [ADDR_W:0]   BusyCnt
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] rf_q [DEPTH];
  logic [DATA_W-1:0] rd1_q, rd1_d, rd2_q, rd2_d;
  logic [DEPTH-1:0]  busy_q, busy_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic              wr_en, set_en, set_inc, clr_dec;
  logic              zero1, zero2, fwd1, fwd2;

  always_comb begin
    zero1  = ZERO_REG && (PR1 == '0);
    zero2  = ZERO_REG && (PR2 == '0);
    fwd1   = BYPASS && Write && (WR == PR1);
    fwd2   = BYPASS && Write && (WR == PR2);
    wr_en  = Write && !(ZERO_REG && (WR == '0));
    set_en = Issue && !(ZERO_REG && (IssueRd == '0));

    if (zero1)     rd1_d = '0;
    else if (fwd1) rd1_d = WD;
    else           rd1_d = rf_q[PR1];

    if (zero2)     rd2_d = '0;
    else if (fwd2) rd2_d = WD;
    else           rd2_d = rf_q[PR2];

    Hazard1 = busy_q[PR1] && !fwd1 && !zero1;
    Hazard2 = busy_q[PR2] && !fwd2 && !zero2;

    // Set is applied after clear so a same-register issue keeps the bit busy.
    busy_d = busy_q;
    if (Write)  busy_d[WR]      = 1'b0;
    if (set_en) busy_d[IssueRd] = 1'b1;

    set_inc = set_en && !busy_q[IssueRd];
    clr_dec = Write && busy_q[WR] && !(set_en && (IssueRd == WR));
    cnt_d   = cnt_q + (ADDR_W+1)'(set_inc) - (ADDR_W+1)'(clr_dec);
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < DEPTH; i++) rf_q[i] <= '0;
      rd1_q  <= '0;
      rd2_q  <= '0;
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (wr_en) rf_q[WR] <= WD;
      if (RE) begin
        rd1_q <= rd1_d;
        rd2_q <= rd2_d;
      end
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign RD1     = rd1_q;
  assign RD2     = rd2_q;
  assign BusyCnt = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_reg_file_sb.sv
`default_nettype none
// tb_reg_file_sb: directed stimulus with a cycle-tagged expectation queue checked
// by an independent negedge monitor. Revision: 1.0
module tb_reg_file_sb;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        w, re, iss;
  logic [4:0]  wr, pr1, pr2, ird;
  logic [31:0] wd;
  logic        w2, re2, iss2;
  logic [2:0]  wr2, p1_2, p2_2, ird2;
  logic [31:0] wd2;

  logic [31:0] rd1_0, rd2_0, rd1_1, rd2_1, rd1_2, rd2_2;
  logic        h1_0, h2_0, h1_1, h2_1, h1_2, h2_2;
  logic [5:0]  cnt_0, cnt_1;
  logic [3:0]  cnt_2;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    int          cyc;
    int          sel;
    logic [31:0] val;
  } exp_t;
  exp_t q[$];

  string nm [15] = '{"u0_RD1", "u0_RD2", "u0_Hazard1", "u0_Hazard2", "u0_BusyCnt",
                     "u1_RD1", "u1_RD2", "u1_Hazard1", "u1_Hazard2", "u1_BusyCnt",
                     "u2_RD1", "u2_RD2", "u2_Hazard1", "u2_Hazard2", "u2_BusyCnt"};

  reg_file_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1'b1), .BYPASS(1'b1)) u0 (
    .Clk(Clk), .Reset(Reset), .Write(w), .WR(wr), .WD(wd), .RE(re), .PR1(pr1), .PR2(pr2),
    .RD1(rd1_0), .RD2(rd2_0), .Issue(iss), .IssueRd(ird), .Hazard1(h1_0), .Hazard2(h2_0),
    .BusyCnt(cnt_0));

  reg_file_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1'b1), .BYPASS(1'b0)) u1 (
    .Clk(Clk), .Reset(Reset), .Write(w), .WR(wr), .WD(wd), .RE(re), .PR1(pr1), .PR2(pr2),
    .RD1(rd1_1), .RD2(rd2_1), .Issue(iss), .IssueRd(ird), .Hazard1(h1_1), .Hazard2(h2_1),
    .BusyCnt(cnt_1));

  reg_file_sb #(.DATA_W(32), .ADDR_W(3), .ZERO_REG(1'b1), .BYPASS(1'b1)) u2 (
    .Clk(Clk), .Reset(Reset), .Write(w2), .WR(wr2), .WD(wd2), .RE(re2), .PR1(p1_2),
    .PR2(p2_2), .RD1(rd1_2), .RD2(rd2_2), .Issue(iss2), .IssueRd(ird2), .Hazard1(h1_2),
    .Hazard2(h2_2), .BusyCnt(cnt_2));

  always #5 Clk = ~Clk;

  always @(posedge Clk) cyc <= cyc + 1;

  function automatic logic [31:0] get(input int sel);
    case (sel)
      0:  return rd1_0;
      1:  return rd2_0;
      2:  return 32'(h1_0);
      3:  return 32'(h2_0);
      4:  return 32'(cnt_0);
      5:  return rd1_1;
      6:  return rd2_1;
      7:  return 32'(h1_1);
      8:  return 32'(h2_1);
      9:  return 32'(cnt_1);
      10: return rd1_2;
      11: return rd2_2;
      12: return 32'(h1_2);
      13: return 32'(h2_2);
      14: return 32'(cnt_2);
      default: return 32'hxxxx_xxxx;
    endcase
  endfunction

  task automatic chk(input int sel, input logic [31:0] exp);
    logic [31:0] act;
    act = get(sel);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", nm[sel], cyc, act, exp);
    end
  endtask

  // Expect signal sel to equal val at the negedge dc cycles after the current one.
  task automatic expect_at(input int sel, input logic [31:0] val, input int dc);
    exp_t e;
    e.cyc = cyc + dc;
    e.sel = sel;
    e.val = val;
    q.push_back(e);
  endtask

  always @(negedge Clk) begin
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].cyc == cyc) begin
        chk(q[i].sel, q[i].val);
        q.delete(i);
      end else if (q[i].cyc < cyc) begin
        checks++;
        errors++;
        $display("FAIL %s stale expectation for cycle %0d: got none expected %h",
                 nm[q[i].sel], q[i].cyc, q[i].val);
        q.delete(i);
      end
    end
  end

  task automatic idle();
    w = 0; wr = 0; wd = 0; re = 0; pr1 = 0; pr2 = 0; iss = 0; ird = 0;
    w2 = 0; wr2 = 0; wd2 = 0; re2 = 0; p1_2 = 0; p2_2 = 0; iss2 = 0; ird2 = 0;
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
    idle();
  endtask

  initial begin
    Reset = 1'b1;
    idle();
    pr1 = 5'd3;
    repeat (2) @(posedge Clk);
    #2;
    chk(0, 32'h0); chk(1, 32'h0); chk(4, 32'h0); chk(2, 32'h0);
    @(posedge Clk);
    #1;
    Reset = 1'b0;
    idle();

    // Build prior state: rf[2]=0x55, rf[3]=0x77, busy[3], RD1=0x55
    step(); w = 1; wr = 5'd2; wd = 32'h55;
    step(); w = 1; wr = 5'd3; wd = 32'h77;
    step(); re = 1; pr1 = 5'd2; iss = 1; ird = 5'd3;
    expect_at(0, 32'h55, 1); expect_at(4, 32'd1, 1);
    step(); pr1 = 5'd3;
    expect_at(2, 32'd1, 0);
    @(negedge Clk);
    #1;
    Reset = 1'b1;
    #1;
    chk(0, 32'h0); chk(1, 32'h0); chk(4, 32'h0); chk(9, 32'h0); chk(2, 32'h0);
    @(posedge Clk);
    #1;
    Reset = 1'b0;
    idle();
    re = 1; pr1 = 5'd3;
    expect_at(0, 32'h0, 1); expect_at(4, 32'h0, 1);

    // Write then read, and the zero register
    step(); w = 1; wr = 5'd7; wd = 32'hDEADBEEF;
    step(); re = 1; pr1 = 5'd7;
    expect_at(0, 32'hDEADBEEF, 1); expect_at(5, 32'hDEADBEEF, 1);
    step(); w = 1; wr = 5'd0; wd = 32'h1234;
    step(); re = 1; pr2 = 5'd0;
    expect_at(1, 32'h0, 1); expect_at(6, 32'h0, 1);

    // Same-edge bypass versus pre-write array value
    step(); w = 1; wr = 5'd5; wd = 32'h11111111;
    step(); w = 1; wr = 5'd5; wd = 32'hA5A5A5A5; re = 1; pr1 = 5'd5; pr2 = 5'd5;
    expect_at(0, 32'hA5A5A5A5, 1); expect_at(1, 32'hA5A5A5A5, 1);
    expect_at(5, 32'h11111111, 1); expect_at(6, 32'h11111111, 1);
    step(); re = 1; pr1 = 5'd5;
    expect_at(5, 32'hA5A5A5A5, 1);

    // Scoreboard set, hazard, forwarded clear
    step(); iss = 1; ird = 5'd9;
    expect_at(4, 32'd1, 1); expect_at(9, 32'd1, 1);
    step(); pr1 = 5'd9; pr2 = 5'd9;
    expect_at(2, 32'd1, 0); expect_at(8, 32'd1, 0);
    step(); w = 1; wr = 5'd9; wd = 32'h99; pr1 = 5'd9; pr2 = 5'd9;
    expect_at(2, 32'd0, 0); expect_at(3, 32'd0, 0); expect_at(7, 32'd1, 0);
    expect_at(4, 32'd0, 1); expect_at(9, 32'd0, 1);
    step(); pr1 = 5'd9;
    expect_at(2, 32'd0, 0); expect_at(7, 32'd0, 0);

    // Simultaneous issue and write to a busy register; issue to r0
    step(); iss = 1; ird = 5'd4;
    expect_at(4, 32'd1, 1);
    step(); iss = 1; ird = 5'd4; w = 1; wr = 5'd4; wd = 32'h11; pr2 = 5'd4;
    expect_at(3, 32'd0, 0); expect_at(4, 32'd1, 1);
    step(); re = 1; pr1 = 5'd4; pr2 = 5'd4; iss = 1; ird = 5'd0;
    expect_at(2, 32'd1, 0); expect_at(0, 32'h11, 1); expect_at(1, 32'h11, 1);
    expect_at(4, 32'd1, 1);
    step(); w = 1; wr = 5'd4;
    expect_at(4, 32'd0, 1);

    // Fill and drain the small instance
    for (int i = 1; i < 8; i++) begin
      step(); iss2 = 1; ird2 = 3'(i);
      expect_at(14, 32'(i), 1);
    end
    step(); p1_2 = 3'd3;
    expect_at(12, 32'd1, 0);
    for (int i = 1; i < 8; i++) begin
      step(); w2 = 1; wr2 = 3'(i); wd2 = 32'(i) * 32'h10; re2 = 1; p1_2 = 3'(i); p2_2 = 3'(i);
      expect_at(12, 32'd0, 0); expect_at(13, 32'd0, 0);
      expect_at(10, 32'(i) * 32'h10, 1); expect_at(11, 32'(i) * 32'h10, 1);
      expect_at(14, 32'(7 - i), 1);
    end
    step(); w2 = 1; wr2 = 3'd1; iss2 = 1; ird2 = 3'd0;
    expect_at(14, 32'd0, 1);
    step();

    repeat (3) @(posedge Clk);
    @(negedge Clk);
    #1;
    while (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s expectation for cycle %0d never sampled: got none expected %h",
               nm[q[0].sel], q[0].cyc, q[0].val);
      void'(q.pop_front());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
- Parametrised successor of the pipeline register file: configurable data width and depth.
- Two registered read ports with optional write-to-read bypass, and a hardwired zero register.
- Built-in scoreboard: tracks destination registers with an in-flight write and flags read-after-write hazards to the decode/stall logic.
- Sits between the decode stage (read, issue) and the write-back stage (write).

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, address width; depth = 2**ADDR_W.
- ZERO_REG, 1, 1: register 0 reads as 0, writes to it are ignored, and it is never marked busy. 0: register 0 is ordinary.
- BYPASS, 1, 1: a same-cycle write is forwarded to a matching read. 0: the read returns the pre-write array value.

Ports:
- Clk  in  1  clock; all state updates on rising edge.
- Reset  in  1  asynchronous, active-high reset.
- Write  in  1  write-back enable.
- WR  in  ADDR_W  write-back address.
- WD  in  DATA_W  write-back data.
- RE  in  1  read enable for both ports.
- PR1  in  ADDR_W  read address, port 1.
- PR2  in  ADDR_W  read address, port 2.
- RD1  out  DATA_W  registered read data, port 1.
- RD2  out  DATA_W  registered read data, port 2.
- Issue  in  1  an instruction with a destination register issues this cycle.
- IssueRd  in  ADDR_W  destination register of the issuing instruction.
- Hazard1  out  1  combinational: PR1 has a pending, unforwarded write.
- Hazard2  out  1  combinational: PR2 has a pending, unforwarded write.
- BusyCnt  out  ADDR_W+1  registered count of busy registers.

Behaviour:
- Reset (async, immediate, any time including mid-write or mid-issue):
  - all array entries = 0; RD1 = RD2 = 0; all busy bits = 0; BusyCnt = 0.
  - Reset has priority over every other input.
  - First update after release is on the next rising Clk edge.
- Write, on rising edge when Write = 1:
  - rf[WR] <= WD, except when ZERO_REG = 1 and WR = 0 (write dropped).
- Read, on rising edge when RE = 1 (latency 1 cycle):
  - RDn <= 0 if ZERO_REG = 1 and PRn = 0.
  - else RDn <= WD if BYPASS = 1 and Write = 1 and WR = PRn.
  - else RDn <= rf[PRn] (value before this edge's write).
  - RE = 0: RD1/RD2 hold.
  - Both ports are independent; PR1 = PR2 is legal and returns identical data.
- Scoreboard, one busy bit per register, updated on rising edge:
  - Clear: busy[WR] <= 0 when Write = 1.
  - Set: busy[IssueRd] <= 1 when Issue = 1, except when ZERO_REG = 1 and IssueRd = 0.
  - Issue and Write to the same register in the same cycle: set wins (the newer producer is in flight), and the write still updates the array.
  - Issue to an already-busy register: stays busy, no error; there is no multi-producer counting.
  - Write to a non-busy register: array updated, busy stays 0.
- BusyCnt:
  - Equals the population count of the busy bits after the edge.
  - Updated incrementally: +1 for a set of a non-busy bit, -1 for a clear of a busy bit, net 0 when both apply to the same register.
  - Range 0..2**ADDR_W (or 2**ADDR_W-1 with ZERO_REG); never wraps.
- Hazard (combinational from current inputs and busy bits):
  - Hazardn = busy[PRn] AND NOT (BYPASS = 1 AND Write = 1 AND WR = PRn).
  - Forced 0 when ZERO_REG = 1 and PRn = 0.
  - Hazardn is independent of RE.
- Array contents are not otherwise initialised; simulation-only preload is not part of this block.

Test Plan:
- Reset with prior state: assert Reset mid-cycle with busy[3] = 1 and RD1 = 0x55 -> RD1, RD2 and BusyCnt go to 0 immediately; Hazard1 = 0 with PR1 = 3; rf[3] reads 0.
- Write then read: write WR = 7, WD = 0xDEADBEEF; next cycle RE = 1, PR1 = 7 -> RD1 = 0xDEADBEEF one cycle later. Also write WR = 0, WD = 0x1234; read PR2 = 0 -> RD2 = 0.
- Bypass, same edge: Write = 1, WR = 5, WD = 0xA5A5A5A5, with RE = 1, PR1 = PR2 = 5 -> RD1 = RD2 = 0xA5A5A5A5 with BYPASS = 1. With BYPASS = 0 -> old rf[5].
- Scoreboard: Issue IssueRd = 9 -> BusyCnt = 1; PR1 = 9 gives Hazard1 = 1. Write WR = 9 with PR1 = 9 -> Hazard1 = 0 in that cycle (bypass); next cycle busy[9] = 0, BusyCnt = 0.
- Simultaneous events: busy[4] = 1; same cycle Issue IssueRd = 4 and Write WR = 4, WD = 0x11 -> busy[4] stays 1, BusyCnt unchanged, rf[4] = 0x11. Also Issue IssueRd = 0 -> BusyCnt unchanged.
- Fill and drain, ADDR_W = 3, ZERO_REG = 1: issue regs 1..7 -> BusyCnt = 7. Write all 7 -> BusyCnt = 0, with no wrap or underflow after one extra write to reg 1.
